// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, main-decoder class codes,
// R-type funct codes and default widths for the issue stage and the ALU.
package alu_pkg;

   localparam int NB_DATA_DEF       = 32;
   localparam int NB_ALU_OPCODE_DEF = 4;
   localparam int NB_REG_ADDR_DEF   = 5;

   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SLL  = 4'b0000;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SRAV = 4'b0001;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SRL  = 4'b0010;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SRA  = 4'b0011;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_AND  = 4'b0100;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SRLV = 4'b0110;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_NOR  = 4'b0111;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SLT  = 4'b1001;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SLLV = 4'b1010;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_SUB  = 4'b1011;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_ADD  = 4'b1100;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_OR   = 4'b1101;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_XOR  = 4'b1110;
   localparam logic [NB_ALU_OPCODE_DEF-1:0] ALU_LUI  = 4'b1111;

   typedef enum logic [3:0] {
      CLASS_RTYPE  = 4'b0000,
      CLASS_ADDI   = 4'b0001,
      CLASS_ADDIU  = 4'b0010,
      CLASS_SLTI   = 4'b0011,
      CLASS_ANDI   = 4'b0100,
      CLASS_ORI    = 4'b0101,
      CLASS_XORI   = 4'b0110,
      CLASS_LUI    = 4'b0111,
      CLASS_BRANCH = 4'b1000
   } alu_class_e;

   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;
   localparam logic [5:0] FUNCT_SRAV = 6'b000111;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational translation of class/funct/immediate/register data into
// the next ALU opcode, operand pair, signed flag and illegal flag.
module alu_issue_decode
   import alu_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF
) (
   input  logic [3:0]                   alu_class,
   input  logic [5:0]                   funct,
   input  logic [4:0]                   shamt,
   input  logic [15:0]                  imm,
   input  logic [NB_DATA-1:0]           rs_data,
   input  logic [NB_DATA-1:0]           rt_data,
   output logic [NB_ALU_OPCODE_DEF-1:0] alu_opcode,
   output logic [NB_DATA-1:0]           first_operator,
   output logic [NB_DATA-1:0]           second_operator,
   output logic                         signed_operation,
   output logic                         illegal
);

   alu_class_e         cls;
   logic [NB_DATA-1:0] sext_imm;
   logic [NB_DATA-1:0] zext_imm;
   logic [NB_DATA-1:0] zext_shamt;
   logic [NB_DATA-1:0] zext_rs_shift;

   assign cls           = alu_class_e'(alu_class);
   assign sext_imm      = {{(NB_DATA-16){imm[15]}}, imm};
   assign zext_imm      = {{(NB_DATA-16){1'b0}}, imm};
   assign zext_shamt    = {{(NB_DATA-5){1'b0}}, shamt};
   assign zext_rs_shift = {{(NB_DATA-5){1'b0}}, rs_data[4:0]};

   // Variable shifts reuse the fixed-shift codes; only the amount source differs.
   always_comb begin
      alu_opcode       = ALU_SLL;
      first_operator   = rs_data;
      second_operator  = rt_data;
      signed_operation = 1'b0;
      illegal          = 1'b0;
      case (cls)
         CLASS_RTYPE: begin
            case (funct)
               FUNCT_SLL:  begin alu_opcode = ALU_SLL; first_operator = rt_data; second_operator = zext_shamt; end
               FUNCT_SRL:  begin alu_opcode = ALU_SRL; first_operator = rt_data; second_operator = zext_shamt; end
               FUNCT_SRA:  begin alu_opcode = ALU_SRA; first_operator = rt_data; second_operator = zext_shamt; end
               FUNCT_SLLV: begin alu_opcode = ALU_SLL; first_operator = rt_data; second_operator = zext_rs_shift; end
               FUNCT_SRLV: begin alu_opcode = ALU_SRL; first_operator = rt_data; second_operator = zext_rs_shift; end
               FUNCT_SRAV: begin alu_opcode = ALU_SRA; first_operator = rt_data; second_operator = zext_rs_shift; end
               FUNCT_ADD:  begin alu_opcode = ALU_ADD; signed_operation = 1'b1; end
               FUNCT_ADDU: alu_opcode = ALU_ADD;
               FUNCT_SUB:  begin alu_opcode = ALU_SUB; signed_operation = 1'b1; end
               FUNCT_SUBU: alu_opcode = ALU_SUB;
               FUNCT_AND:  alu_opcode = ALU_AND;
               FUNCT_OR:   alu_opcode = ALU_OR;
               FUNCT_XOR:  alu_opcode = ALU_XOR;
               FUNCT_NOR:  alu_opcode = ALU_NOR;
               FUNCT_SLT:  begin alu_opcode = ALU_SLT; signed_operation = 1'b1; end
               default:    illegal = 1'b1;
            endcase
         end
         CLASS_ADDI:   begin alu_opcode = ALU_ADD; second_operator = sext_imm; signed_operation = 1'b1; end
         CLASS_ADDIU:  begin alu_opcode = ALU_ADD; second_operator = sext_imm; end
         CLASS_SLTI:   begin alu_opcode = ALU_SLT; second_operator = sext_imm; signed_operation = 1'b1; end
         CLASS_ANDI:   begin alu_opcode = ALU_AND; second_operator = zext_imm; end
         CLASS_ORI:    begin alu_opcode = ALU_OR;  second_operator = zext_imm; end
         CLASS_XORI:   begin alu_opcode = ALU_XOR; second_operator = zext_imm; end
         CLASS_LUI:    begin alu_opcode = ALU_LUI; first_operator = '0; second_operator = zext_imm; end
         CLASS_BRANCH: alu_opcode = ALU_SUB;
         default:      illegal = 1'b1;
      endcase

      // Illegal entries still flow down the pipe, but as a harmless SLL of zeros.
      if (illegal) begin
         alu_opcode       = ALU_SLL;
         first_operator   = '0;
         second_operator  = '0;
         signed_operation = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU with a valid/ready handshake and flush.
// Optional operand forwarding from MEM/WB is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int NB_DATA       = NB_DATA_DEF,
   parameter int NB_ALU_OPCODE = NB_ALU_OPCODE_DEF,
   parameter int NB_REG_ADDR   = NB_REG_ADDR_DEF
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [3:0]               i_alu_class,
   input  logic [5:0]               i_funct,
   input  logic [4:0]               i_shamt,
   input  logic [15:0]              i_imm,
   input  logic [NB_DATA-1:0]       i_rs_data,
   input  logic [NB_DATA-1:0]       i_rt_data,
   input  logic [NB_REG_ADDR-1:0]   i_rs_addr,
   input  logic [NB_REG_ADDR-1:0]   i_rt_addr,
   input  logic [NB_REG_ADDR-1:0]   i_dest_addr,
`ifdef ALU_ISSUE_FWD_EN
   input  logic                     i_fwd_mem_we,
   input  logic [NB_REG_ADDR-1:0]   i_fwd_mem_addr,
   input  logic [NB_DATA-1:0]       i_fwd_mem_data,
   input  logic                     i_fwd_wb_we,
   input  logic [NB_REG_ADDR-1:0]   i_fwd_wb_addr,
   input  logic [NB_DATA-1:0]       i_fwd_wb_data,
`endif
   input  logic                     i_flush,
   input  logic                     i_ready,
   output logic                     o_valid,
   output logic [NB_ALU_OPCODE-1:0] o_alu_opcode,
   output logic [NB_DATA-1:0]       o_first_operator,
   output logic [NB_DATA-1:0]       o_second_operator,
   output logic                     o_signed_operation,
   output logic [NB_REG_ADDR-1:0]   o_dest_addr,
   output logic                     o_illegal
);

   logic [NB_DATA-1:0]           rs_src;
   logic [NB_DATA-1:0]           rt_src;
   logic [NB_ALU_OPCODE_DEF-1:0] next_opcode;
   logic [NB_DATA-1:0]           next_first;
   logic [NB_DATA-1:0]           next_second;
   logic                         next_signed;
   logic                         next_illegal;
   logic                         ready;

`ifdef ALU_ISSUE_FWD_EN
   // MEM is younger than WB, so it wins when both hold the same register.
   always_comb begin
      rs_src = i_rs_data;
      if (i_fwd_mem_we && (i_fwd_mem_addr == i_rs_addr) && (i_fwd_mem_addr != '0))
         rs_src = i_fwd_mem_data;
      else if (i_fwd_wb_we && (i_fwd_wb_addr == i_rs_addr) && (i_fwd_wb_addr != '0))
         rs_src = i_fwd_wb_data;

      rt_src = i_rt_data;
      if (i_fwd_mem_we && (i_fwd_mem_addr == i_rt_addr) && (i_fwd_mem_addr != '0))
         rt_src = i_fwd_mem_data;
      else if (i_fwd_wb_we && (i_fwd_wb_addr == i_rt_addr) && (i_fwd_wb_addr != '0))
         rt_src = i_fwd_wb_data;
   end
`else
   logic unused_src_addr;

   assign rs_src          = i_rs_data;
   assign rt_src          = i_rt_data;
   assign unused_src_addr = ^{i_rs_addr, i_rt_addr};
`endif

   alu_issue_decode #(
      .NB_DATA (NB_DATA)
   ) u_decode (
      .alu_class        (i_alu_class),
      .funct            (i_funct),
      .shamt            (i_shamt),
      .imm              (i_imm),
      .rs_data          (rs_src),
      .rt_data          (rt_src),
      .alu_opcode       (next_opcode),
      .first_operator   (next_first),
      .second_operator  (next_second),
      .signed_operation (next_signed),
      .illegal          (next_illegal)
   );

   assign ready   = ~o_valid | i_ready;
   assign o_ready = ready;

   // Flush outranks a load; a stalled entry simply keeps every field.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_valid            <= 1'b0;
         o_alu_opcode       <= '0;
         o_first_operator   <= '0;
         o_second_operator  <= '0;
         o_signed_operation <= 1'b0;
         o_dest_addr        <= '0;
         o_illegal          <= 1'b0;
      end else if (i_flush) begin
         o_valid   <= 1'b0;
         o_illegal <= 1'b0;
      end else if (i_valid && ready) begin
         o_valid            <= 1'b1;
         o_alu_opcode       <= NB_ALU_OPCODE'(next_opcode);
         o_first_operator   <= next_first;
         o_second_operator  <= next_second;
         o_signed_operation <= next_signed;
         o_dest_addr        <= i_dest_addr;
         o_illegal          <= next_illegal;
      end else if (i_ready) begin
         o_valid   <= 1'b0;
         o_illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed issues push expectations,
// a negedge monitor pops and compares on every accepted transfer.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] first;
      logic [31:0] second;
      logic        sgn;
      logic        ill;
      logic [4:0]  dest;
   } exp_t;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_alu_class;
   logic [5:0]  i_funct;
   logic [4:0]  i_shamt;
   logic [15:0] i_imm;
   logic [31:0] i_rs_data;
   logic [31:0] i_rt_data;
   logic [4:0]  i_rs_addr;
   logic [4:0]  i_rt_addr;
   logic [4:0]  i_dest_addr;
   logic        i_flush;
   logic        i_ready;
   logic        o_valid;
   logic [3:0]  o_alu_opcode;
   logic [31:0] o_first_operator;
   logic [31:0] o_second_operator;
   logic        o_signed_operation;
   logic [4:0]  o_dest_addr;
   logic        o_illegal;
`ifdef ALU_ISSUE_FWD_EN
   logic        i_fwd_mem_we;
   logic [4:0]  i_fwd_mem_addr;
   logic [31:0] i_fwd_mem_data;
   logic        i_fwd_wb_we;
   logic [4:0]  i_fwd_wb_addr;
   logic [31:0] i_fwd_wb_data;
`endif

   exp_t sb[$];
   exp_t mon_exp;
   exp_t snap;
   logic stall_prev = 1'b0;
   int   checks = 0;
   int   errors = 0;

   alu_issue_stage dut (
      .i_clock            (i_clock),
      .i_reset            (i_reset),
      .i_valid            (i_valid),
      .o_ready            (o_ready),
      .i_alu_class        (i_alu_class),
      .i_funct            (i_funct),
      .i_shamt            (i_shamt),
      .i_imm              (i_imm),
      .i_rs_data          (i_rs_data),
      .i_rt_data          (i_rt_data),
      .i_rs_addr          (i_rs_addr),
      .i_rt_addr          (i_rt_addr),
      .i_dest_addr        (i_dest_addr),
`ifdef ALU_ISSUE_FWD_EN
      .i_fwd_mem_we       (i_fwd_mem_we),
      .i_fwd_mem_addr     (i_fwd_mem_addr),
      .i_fwd_mem_data     (i_fwd_mem_data),
      .i_fwd_wb_we        (i_fwd_wb_we),
      .i_fwd_wb_addr      (i_fwd_wb_addr),
      .i_fwd_wb_data      (i_fwd_wb_data),
`endif
      .i_flush            (i_flush),
      .i_ready            (i_ready),
      .o_valid            (o_valid),
      .o_alu_opcode       (o_alu_opcode),
      .o_first_operator   (o_first_operator),
      .o_second_operator  (o_second_operator),
      .o_signed_operation (o_signed_operation),
      .o_dest_addr        (o_dest_addr),
      .o_illegal          (o_illegal)
   );

   always #5 i_clock = ~i_clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, input logic [31:0] first, input logic [31:0] second,
                               input logic sgn, input logic ill, input logic [4:0] dest);
      exp_t e;
      e.op = op; e.first = first; e.second = second; e.sgn = sgn; e.ill = ill; e.dest = dest;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the edge that loads the entry.
   task automatic applyStimulus(input logic [3:0] cls, input logic [5:0] funct, input logic [4:0] shamt,
                                input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [4:0] dest, input logic push, input exp_t e);
      logic accepted;
      i_valid     = 1'b1;
      i_alu_class = cls;
      i_funct     = funct;
      i_shamt     = shamt;
      i_imm       = imm;
      i_rs_data   = rs;
      i_rt_data   = rt;
      i_dest_addr = dest;
      accepted    = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge i_clock);
         if (o_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL issue_timeout actual=o_ready 0 required=1");
      end else if (push) begin
         sb.push_back(e);
      end
      @(posedge i_clock);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clock);
      #1;
   endtask

   // Monitor: compare on transfers, and verify a stalled entry never changes.
   always @(negedge i_clock) begin
      if (!i_reset) begin
         if (stall_prev) begin
            checkOutput("hold_opcode", {28'd0, o_alu_opcode}, {28'd0, snap.op});
            checkOutput("hold_first", o_first_operator, snap.first);
            checkOutput("hold_second", o_second_operator, snap.second);
            checkOutput("hold_dest", {27'd0, o_dest_addr}, {27'd0, snap.dest});
         end
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output actual=valid opcode %h required=no entry", o_alu_opcode);
            end else begin
               mon_exp = sb.pop_front();
               checkOutput("opcode", {28'd0, o_alu_opcode}, {28'd0, mon_exp.op});
               checkOutput("first", o_first_operator, mon_exp.first);
               checkOutput("second", o_second_operator, mon_exp.second);
               checkOutput("signed", {31'd0, o_signed_operation}, {31'd0, mon_exp.sgn});
               checkOutput("illegal", {31'd0, o_illegal}, {31'd0, mon_exp.ill});
               checkOutput("dest", {27'd0, o_dest_addr}, {27'd0, mon_exp.dest});
            end
         end
         stall_prev = o_valid && !i_ready && !i_flush;
         snap = mk(o_alu_opcode, o_first_operator, o_second_operator, o_signed_operation, o_illegal, o_dest_addr);
      end
   end

   initial begin
      i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      i_alu_class = '0; i_funct = '0; i_shamt = '0; i_imm = '0;
      i_rs_data = '0; i_rt_data = '0; i_rs_addr = 5'd1; i_rt_addr = 5'd2; i_dest_addr = '0;
`ifdef ALU_ISSUE_FWD_EN
      i_fwd_mem_we = 1'b0; i_fwd_mem_addr = '0; i_fwd_mem_data = '0;
      i_fwd_wb_we = 1'b0; i_fwd_wb_addr = '0; i_fwd_wb_data = '0;
`endif
      // Inputs set to a legal instruction during reset: reset must win.
      i_valid = 1'b1; i_alu_class = 4'b0001; i_imm = 16'h00FF; i_dest_addr = 5'd9;
      repeat (3) @(posedge i_clock);
      #1;
      i_valid = 1'b0;
      i_reset = 1'b0;
      @(negedge i_clock);
      checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("reset_ready", {31'd0, o_ready}, 32'd1);
      checkOutput("reset_opcode", {28'd0, o_alu_opcode}, 32'd0);
      checkOutput("reset_first", o_first_operator, 32'd0);
      checkOutput("reset_second", o_second_operator, 32'd0);
      checkOutput("reset_signed", {31'd0, o_signed_operation}, 32'd0);
      checkOutput("reset_illegal", {31'd0, o_illegal}, 32'd0);
      checkOutput("reset_dest", {27'd0, o_dest_addr}, 32'd0);
      idle(1);

      // Streaming issues with the execute stage always ready
      applyStimulus(4'b0000, 6'b100000, 5'd0, 16'h0000, 32'h7FFFFFFF, 32'h00000001, 5'd5, 1'b1,
                    mk(4'b1100, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 5'd5));
      applyStimulus(4'b0001, 6'b000000, 5'd0, 16'hFFFF, 32'h00000010, 32'h12345678, 5'd6, 1'b1,
                    mk(4'b1100, 32'h00000010, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd6));
      applyStimulus(4'b0101, 6'b000000, 5'd0, 16'hFFFF, 32'h00000005, 32'h0, 5'd7, 1'b1,
                    mk(4'b1101, 32'h00000005, 32'h0000FFFF, 1'b0, 1'b0, 5'd7));
      applyStimulus(4'b0111, 6'b000000, 5'd0, 16'h1234, 32'h0000DEAD, 32'h0, 5'd8, 1'b1,
                    mk(4'b1111, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 5'd8));
      applyStimulus(4'b0000, 6'b000110, 5'd0, 16'h0000, 32'h00000025, 32'h80000000, 5'd9, 1'b1,
                    mk(4'b0010, 32'h80000000, 32'h00000005, 1'b0, 1'b0, 5'd9));
      applyStimulus(4'b0000, 6'b000011, 5'd7, 16'h0000, 32'h0000001F, 32'hF0000000, 5'd10, 1'b1,
                    mk(4'b0011, 32'hF0000000, 32'h00000007, 1'b0, 1'b0, 5'd10));
      applyStimulus(4'b0011, 6'b000000, 5'd0, 16'h8000, 32'h00000003, 32'h0, 5'd11, 1'b1,
                    mk(4'b1001, 32'h00000003, 32'hFFFF8000, 1'b1, 1'b0, 5'd11));
      applyStimulus(4'b0010, 6'b000000, 5'd0, 16'h8000, 32'h00001000, 32'h0, 5'd12, 1'b1,
                    mk(4'b1100, 32'h00001000, 32'hFFFF8000, 1'b0, 1'b0, 5'd12));
      applyStimulus(4'b1000, 6'b000000, 5'd0, 16'h0004, 32'h00000005, 32'h00000005, 5'd0, 1'b1,
                    mk(4'b1011, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 5'd0));
      applyStimulus(4'b0100, 6'b000000, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'h0, 5'd13, 1'b1,
                    mk(4'b0100, 32'hFFFFFFFF, 32'h00008001, 1'b0, 1'b0, 5'd13));
      applyStimulus(4'b0110, 6'b000000, 5'd0, 16'h00FF, 32'h0000F0F0, 32'h0, 5'd14, 1'b1,
                    mk(4'b1110, 32'h0000F0F0, 32'h000000FF, 1'b0, 1'b0, 5'd14));
      applyStimulus(4'b0000, 6'b100111, 5'd0, 16'h0000, 32'h0F0F0F0F, 32'h00FF00FF, 5'd15, 1'b1,
                    mk(4'b0111, 32'h0F0F0F0F, 32'h00FF00FF, 1'b0, 1'b0, 5'd15));
      applyStimulus(4'b0000, 6'b101010, 5'd0, 16'h0000, 32'hFFFFFFFE, 32'h00000001, 5'd16, 1'b1,
                    mk(4'b1001, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 5'd16));
      applyStimulus(4'b0000, 6'b100011, 5'd0, 16'h0000, 32'h00000009, 32'h00000004, 5'd17, 1'b1,
                    mk(4'b1011, 32'h00000009, 32'h00000004, 1'b0, 1'b0, 5'd17));
      applyStimulus(4'b0000, 6'b100010, 5'd0, 16'h0000, 32'h00000002, 32'h00000003, 5'd18, 1'b1,
                    mk(4'b1011, 32'h00000002, 32'h00000003, 1'b1, 1'b0, 5'd18));

      // Stall: A held for three cycles while B waits, then B follows
      idle(1);
      i_ready = 1'b0;
      applyStimulus(4'b0000, 6'b100001, 5'd0, 16'h0000, 32'h00000011, 32'h00000022, 5'd19, 1'b1,
                    mk(4'b1100, 32'h00000011, 32'h00000022, 1'b0, 1'b0, 5'd19));
      fork
         applyStimulus(4'b0000, 6'b100100, 5'd0, 16'h0000, 32'hAAAA5555, 32'h0000FFFF, 5'd20, 1'b1,
                       mk(4'b0100, 32'hAAAA5555, 32'h0000FFFF, 1'b0, 1'b0, 5'd20));
         begin
            repeat (3) begin
               @(negedge i_clock);
               checkOutput("stall_ready", {31'd0, o_ready}, 32'd0);
            end
            @(posedge i_clock);
            #1;
            i_ready = 1'b1;
         end
      join
      @(negedge i_clock);
      checkOutput("after_stall_valid", {31'd0, o_valid}, 32'd1);
      idle(1);

      // Flush with a simultaneous issue: the issue is dropped
      i_flush = 1'b1;
      applyStimulus(4'b0000, 6'b100101, 5'd0, 16'h0000, 32'h1, 32'h2, 5'd21, 1'b0,
                    mk(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0));
      i_flush = 1'b0;
      @(negedge i_clock);
      checkOutput("flush_drop_valid", {31'd0, o_valid}, 32'd0);
      idle(1);

      // Flush of an entry held by a stalled execute stage
      i_ready = 1'b0;
      applyStimulus(4'b0000, 6'b100110, 5'd0, 16'h0000, 32'h3, 32'h4, 5'd22, 1'b0,
                    mk(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0));
      @(negedge i_clock);
      checkOutput("held_valid", {31'd0, o_valid}, 32'd1);
      i_flush = 1'b1;
      @(posedge i_clock);
      #1;
      i_flush = 1'b0;
      @(negedge i_clock);
      checkOutput("flush_held_valid", {31'd0, o_valid}, 32'd0);
      i_ready = 1'b1;
      idle(1);

      // Illegal encodings are accepted as zeroed SLL with the flag set
      applyStimulus(4'b0000, 6'b101011, 5'd3, 16'h1234, 32'h55555555, 32'h66666666, 5'd23, 1'b1,
                    mk(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 5'd23));
      applyStimulus(4'b1010, 6'b100000, 5'd0, 16'hFFFF, 32'h77777777, 32'h88888888, 5'd24, 1'b1,
                    mk(4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 5'd24));
      applyStimulus(4'b0000, 6'b100101, 5'd0, 16'h0000, 32'h00F00000, 32'h0000000F, 5'd25, 1'b1,
                    mk(4'b1101, 32'h00F00000, 32'h0000000F, 1'b0, 1'b0, 5'd25));

`ifdef ALU_ISSUE_FWD_EN
      // MEM beats WB on rs; rt comes from the register file
      i_rs_addr = 5'd3; i_rt_addr = 5'd4;
      i_fwd_mem_we = 1'b1; i_fwd_mem_addr = 5'd3; i_fwd_mem_data = 32'h000000AA;
      i_fwd_wb_we = 1'b1; i_fwd_wb_addr = 5'd3; i_fwd_wb_data = 32'h000000BB;
      applyStimulus(4'b0000, 6'b100001, 5'd0, 16'h0000, 32'h00000011, 32'h00000022, 5'd26, 1'b1,
                    mk(4'b1100, 32'h000000AA, 32'h00000022, 1'b0, 1'b0, 5'd26));
      // WB alone feeds rt
      i_fwd_mem_addr = 5'd7; i_fwd_wb_addr = 5'd4;
      applyStimulus(4'b0000, 6'b100001, 5'd0, 16'h0000, 32'h00000011, 32'h00000022, 5'd27, 1'b1,
                    mk(4'b1100, 32'h00000011, 32'h000000BB, 1'b0, 1'b0, 5'd27));
      // Register zero is never forwarded
      i_rs_addr = 5'd0; i_fwd_mem_addr = 5'd0; i_fwd_wb_addr = 5'd0;
      applyStimulus(4'b0000, 6'b100001, 5'd0, 16'h0000, 32'h00000011, 32'h00000022, 5'd28, 1'b1,
                    mk(4'b1100, 32'h00000011, 32'h00000022, 1'b0, 1'b0, 5'd28));
      // Forwarded rs also supplies the variable shift amount
      i_rs_addr = 5'd3; i_fwd_mem_addr = 5'd3; i_fwd_mem_data = 32'h00000025; i_fwd_wb_we = 1'b0;
      applyStimulus(4'b0000, 6'b000100, 5'd0, 16'h0000, 32'h00000001, 32'h00000003, 5'd29, 1'b1,
                    mk(4'b0000, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 5'd29));
      i_fwd_mem_we = 1'b0;
`endif

      for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge i_clock);
      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      idle(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
